// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI read arbiter.
// Outstanding counts are CNT_W bits wide, so MAX_OUTS is limited to 15.
package axi_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_e;

  localparam logic M0_IDX       = 1'b0;
  localparam logic M1_IDX       = 1'b1;
  localparam int   MAX_OUTS_DEF = 4;
  localparam int   CNT_W        = 4;

endpackage

// File: rtl/axi_rd_outs_cnt.sv
// Saturating outstanding-burst counter, one instance per master.
// A simultaneous inc and dec cancel out; inc at full or dec at empty is ignored.
module axi_rd_outs_cnt
  import axi_rd_arb_pkg::*;
#(
  parameter int MAX_OUTS = MAX_OUTS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTS);

  assign full  = (count >= MAX_C);
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Two-master AXI read-address arbiter with response routing by the top bit of s_rid.
// Define ARB_FIXED_PRIO_EN to give master 1 fixed priority instead of round-robin.
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter int MAX_OUTS       = MAX_OUTS_DEF,
  parameter int BUS_ID_WIDTH   = 4,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  // master 0 (IFU)
  input  logic [BUS_ID_WIDTH-1:0]   m0_arid,
  input  logic [BUS_ADDR_WIDTH-1:0] m0_araddr,
  input  logic [7:0]                m0_arlen,
  input  logic [2:0]                m0_arsize,
  input  logic [1:0]                m0_arburst,
  input  logic                      m0_arvalid,
  output logic                      m0_arready,
  output logic [BUS_ID_WIDTH-1:0]   m0_rid,
  output logic [BUS_DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]                m0_rresp,
  output logic                      m0_rlast,
  output logic                      m0_rvalid,
  input  logic                      m0_rready,
  // master 1 (LSU)
  input  logic [BUS_ID_WIDTH-1:0]   m1_arid,
  input  logic [BUS_ADDR_WIDTH-1:0] m1_araddr,
  input  logic [7:0]                m1_arlen,
  input  logic [2:0]                m1_arsize,
  input  logic [1:0]                m1_arburst,
  input  logic                      m1_arvalid,
  output logic                      m1_arready,
  output logic [BUS_ID_WIDTH-1:0]   m1_rid,
  output logic [BUS_DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]                m1_rresp,
  output logic                      m1_rlast,
  output logic                      m1_rvalid,
  input  logic                      m1_rready,
  // shared slave side
  output logic [BUS_ID_WIDTH:0]     s_arid,
  output logic [BUS_ADDR_WIDTH-1:0] s_araddr,
  output logic [7:0]                s_arlen,
  output logic [2:0]                s_arsize,
  output logic [1:0]                s_arburst,
  output logic                      s_arlock,
  output logic [3:0]                s_arcache,
  output logic [2:0]                s_arprot,
  output logic [3:0]                s_arqos,
  output logic                      s_aruser,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  input  logic [BUS_ID_WIDTH:0]     s_rid,
  input  logic [BUS_DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]                s_rresp,
  input  logic                      s_rlast,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  output logic                      stray_err_o
);

  arb_state_e       state_q, state_d;
  logic             grant0, grant1, elig0, elig1, tie_win;
  logic             full0, full1, empty0, empty1;
  logic [CNT_W-1:0] cnt_m0, cnt_m1;
  logic             r_sel, sel_zero, r_last_hs;
  logic             stray_q;

  assign grant0 = (state_q == ST_GRANT0);
  assign grant1 = (state_q == ST_GRANT1);
  assign elig0  = m0_arvalid && !full0;
  assign elig1  = m1_arvalid && !full1;

`ifdef ARB_FIXED_PRIO_EN
  assign tie_win = M1_IDX;
`else
  // Pointer holds the last granted master; the other one wins the next tie.
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= M1_IDX;
    end else if (s_arvalid && s_arready) begin
      last_q <= grant1;
    end
  end

  assign tie_win = ~last_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (elig0 && elig1) state_d = (tie_win == M1_IDX) ? ST_GRANT1 : ST_GRANT0;
        else if (elig0)     state_d = ST_GRANT0;
        else if (elig1)     state_d = ST_GRANT1;
      end
      ST_GRANT0: if (s_arready) state_d = ST_IDLE;
      ST_GRANT1: if (s_arready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // AR path: the granted master drives the slave until its handshake completes.
  assign s_arvalid  = grant0 || grant1;
  assign m0_arready = grant0 && s_arready;
  assign m1_arready = grant1 && s_arready;
  assign s_arid     = grant1 ? {M1_IDX, m1_arid} : {M0_IDX, m0_arid};
  assign s_araddr   = grant1 ? m1_araddr  : m0_araddr;
  assign s_arlen    = grant1 ? m1_arlen   : m0_arlen;
  assign s_arsize   = grant1 ? m1_arsize  : m0_arsize;
  assign s_arburst  = grant1 ? m1_arburst : m0_arburst;
  assign s_arlock   = 1'b0;
  assign s_arcache  = 4'b0010;
  assign s_arprot   = 3'b100;
  assign s_arqos    = 4'b0000;
  assign s_aruser   = 1'b0;

  // R path: beats for a master with nothing outstanding are swallowed and flagged.
  assign r_sel     = s_rid[BUS_ID_WIDTH];
  assign sel_zero  = (r_sel == M1_IDX) ? (cnt_m1 == '0) : (cnt_m0 == '0);
  assign s_rready  = sel_zero ? 1'b1 : ((r_sel == M1_IDX) ? m1_rready : m0_rready);
  assign r_last_hs = s_rvalid && s_rready && s_rlast;

  assign m0_rvalid = s_rvalid && (r_sel == M0_IDX) && !empty0 && !rst;
  assign m1_rvalid = s_rvalid && (r_sel == M1_IDX) && !empty1 && !rst;
  assign m0_rid    = s_rid[BUS_ID_WIDTH-1:0];
  assign m1_rid    = s_rid[BUS_ID_WIDTH-1:0];
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign m0_rresp  = s_rresp;
  assign m1_rresp  = s_rresp;
  assign m0_rlast  = s_rlast;
  assign m1_rlast  = s_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stray_q <= 1'b0;
    end else begin
      stray_q <= s_rvalid && sel_zero;
    end
  end

  assign stray_err_o = stray_q;

  axi_rd_outs_cnt #(.MAX_OUTS(MAX_OUTS)) u_cnt_m0 (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant0 && s_arready),
    .dec   (r_last_hs && (r_sel == M0_IDX) && !empty0),
    .count (cnt_m0),
    .full  (full0),
    .empty (empty0)
  );

  axi_rd_outs_cnt #(.MAX_OUTS(MAX_OUTS)) u_cnt_m1 (
    .clk   (clk),
    .rst   (rst),
    .inc   (grant1 && s_arready),
    .dec   (r_last_hs && (r_sel == M1_IDX) && !empty1),
    .count (cnt_m1),
    .full  (full1),
    .empty (empty1)
  );

endmodule

// File: tb/tb_axi_rd_arb.sv
// Directed bench for axi_rd_arb: grant order, outstanding limits, R routing, stray beats, reset.
module tb_axi_rd_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m0_arid, m1_arid, m0_rid, m1_rid;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata, s_araddr, s_rdata;
  logic [7:0]  m0_arlen, m1_arlen, s_arlen;
  logic [2:0]  m0_arsize, m1_arsize, s_arsize, s_arprot;
  logic [1:0]  m0_arburst, m1_arburst, s_arburst, m0_rresp, m1_rresp, s_rresp;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [4:0]  s_arid, s_rid;
  logic        s_arlock, s_aruser, s_arvalid, s_arready;
  logic [3:0]  s_arcache, s_arqos;
  logic        s_rlast, s_rvalid, s_rready, stray_err_o;

  int vectors = 0;
  int miscompares = 0;
  logic exp_sel;

  always #5 clk = ~clk;

  axi_rd_arb dut (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
    .s_arqos(s_arqos), .s_aruser(s_aruser), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .stray_err_o(stray_err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 1'b0;
    m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 1'b0;
    m0_rready = 1'b0; m1_rready = 1'b0; s_arready = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_m0_arready", m0_arready, 0);
    chk("rst_m1_arready", m1_arready, 0);
    chk("rst_stray", stray_err_o, 0);
    chk("rst_cnt0", dut.cnt_m0, 0);
    chk("rst_cnt1", dut.cnt_m1, 0);
    rst = 1'b0;

    // Lone m0 request: granted one cycle later, count goes 0 -> 1
    m0_arvalid = 1'b1; m0_arid = 4'h5; m0_araddr = 32'h0000_1000;
    m0_arlen = 8'd3; m0_arsize = 3'd2; m0_arburst = 2'd1; s_arready = 1'b1;
    #1;
    chk("idle_s_arvalid", s_arvalid, 0);
    chk("idle_m0_arready", m0_arready, 0);
    tick();
    chk("g0_s_arvalid", s_arvalid, 1);
    chk("g0_s_arid", s_arid, 5'h05);
    chk("g0_s_araddr", s_araddr, 32'h0000_1000);
    chk("g0_s_arlen", s_arlen, 8'd3);
    chk("g0_s_arburst", s_arburst, 2'd1);
    chk("g0_m0_arready", m0_arready, 1);
    chk("g0_m1_arready", m1_arready, 0);
    chk("const_arcache", s_arcache, 4'b0010);
    chk("const_arprot", s_arprot, 3'b100);
    tick();
    m0_arvalid = 1'b0;
    #1;
    chk("hs_s_arvalid", s_arvalid, 0);
    chk("hs_cnt0", dut.cnt_m0, 1);

    // Last beat routed to m0 retires its burst
    s_rvalid = 1'b1; s_rid = 5'h05; s_rdata = 32'hCAFE_0001; s_rlast = 1'b1; m0_rready = 1'b1;
    #1;
    chk("r0_m0_rvalid", m0_rvalid, 1);
    chk("r0_m1_rvalid", m1_rvalid, 0);
    chk("r0_m0_rid", m0_rid, 4'h5);
    chk("r0_m0_rdata", m0_rdata, 32'hCAFE_0001);
    chk("r0_s_rready", s_rready, 1);
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("r0_cnt0", dut.cnt_m0, 0);
    chk("r0_stray", stray_err_o, 0);

    // Stray beat for m0 with nothing outstanding
    s_rvalid = 1'b1; s_rid = 5'h02; s_rlast = 1'b1; m0_rready = 1'b0;
    #1;
    chk("stray_s_rready", s_rready, 1);
    chk("stray_m0_rvalid", m0_rvalid, 0);
    tick();
    s_rvalid = 1'b0;
    #1;
    chk("stray_pulse", stray_err_o, 1);
    chk("stray_cnt0", dut.cnt_m0, 0);
    tick();
    chk("stray_clear", stray_err_o, 0);

    // m1 fills its MAX_OUTS=4 slots
    m1_arvalid = 1'b1; m1_arid = 4'h3; m1_araddr = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fill_s_arid", s_arid, 5'h13);
      chk("fill_m1_arready", m1_arready, 1);
      tick();
    end
    chk("fill_cnt1", dut.cnt_m1, 4);
    m0_arvalid = 1'b1;
    tick();
    chk("full_m0_wins", s_arid, 5'h05);
    chk("full_m1_arready", m1_arready, 0);
    tick();
    m0_arvalid = 1'b0;
    tick();
    chk("full_m1_blocked", s_arvalid, 0);

    // Last beat for m1 held by backpressure, then delivered
    s_rvalid = 1'b1; s_rid = 5'h13; s_rdata = 32'h1234_5678; s_rlast = 1'b1; m1_rready = 1'b0;
    #1;
    chk("bp_s_rready", s_rready, 0);
    chk("bp_m0_rvalid", m0_rvalid, 0);
    chk("bp_m1_rvalid", m1_rvalid, 1);
    chk("bp_m1_rid", m1_rid, 4'h3);
    tick();
    chk("bp_cnt1", dut.cnt_m1, 4);
    m1_rready = 1'b1;
    #1;
    chk("dlv_s_rready", s_rready, 1);
    chk("dlv_m1_rdata", m1_rdata, 32'h1234_5678);
    tick();
    s_rvalid = 1'b0; m1_rready = 1'b0;
    #1;
    chk("dlv_cnt1", dut.cnt_m1, 3);
    chk("dlv_no_grant_yet", s_arvalid, 0);
    tick();
    chk("reelig_s_arvalid", s_arvalid, 1);
    chk("reelig_s_arid", s_arid, 5'h13);

    // Grant is held while the slave stalls, even with m0 requesting
    s_arready = 1'b0; m0_arvalid = 1'b1;
    #1;
    chk("hold_m1_arready", m1_arready, 0);
    tick();
    chk("hold_s_arvalid", s_arvalid, 1);
    chk("hold_s_arid", s_arid, 5'h13);
    chk("hold_m0_arready", m0_arready, 0);

    // Asynchronous reset while GRANT1 is presenting a request
    rst = 1'b1;
    #1;
    chk("arst_s_arvalid", s_arvalid, 0);
    chk("arst_m1_arready", m1_arready, 0);
    chk("arst_cnt0", dut.cnt_m0, 0);
    chk("arst_cnt1", dut.cnt_m1, 0);
    s_rvalid = 1'b1; s_rid = 5'h13; m1_rready = 1'b1;
    #1;
    chk("arst_m1_rvalid", m1_rvalid, 0);
    s_rvalid = 1'b0; m1_rready = 1'b0;
    tick();
    rst = 1'b0; s_arready = 1'b1; m0_arvalid = 1'b1; m1_arvalid = 1'b1;

    // Both requesting continuously after reset
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_sel = 1'b1;
`else
      exp_sel = (i % 2 == 1);
`endif
      tick();
      chk("tie_s_arid", s_arid, exp_sel ? 5'h13 : 5'h05);
      chk("tie_m0_arready", m0_arready, !exp_sel);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
